// File: rtl/img_pkg.sv
// Shared constants and types for the RGB-to-luma streaming front end.
package img_pkg;

    // Luma weights (sum to 256), rounding constant and final shift.
    localparam int unsigned LUMA_WR  = 77;
    localparam int unsigned LUMA_WG  = 150;
    localparam int unsigned LUMA_WB  = 29;
    localparam int unsigned LUMA_RND = 128;
    localparam int unsigned LUMA_SH  = 8;

    localparam int unsigned PIX_W    = 8;
    localparam int unsigned ACC_W    = 16;
    localparam int unsigned COORD_W  = 16;
    localparam int unsigned SUM_W    = 32;

    typedef logic [15:0] coord_t;

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_t;

    // Per-pixel side information carried alongside the luma pipeline.
    typedef struct packed {
        coord_t row;
        coord_t col;
        logic   eof;
        logic   err;
    } pix_tag_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } frame_state_e;

endpackage

// File: rtl/rgb_luma_mac.sv
// Two-stage luma datapath: weighted products registered, then sum + round + shift.
module rgb_luma_mac
    import img_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  rgb_t             rgb_i,
    output logic             valid_o,
    output logic [PIX_W-1:0] gray_o
);

    logic [ACC_W-1:0] prod_r_q, prod_g_q, prod_b_q;
    logic             valid_s1_q;
    logic [ACC_W-1:0] sum_c;
    logic             valid_s2_q;
    logic [PIX_W-1:0] gray_q;

    // Maximum is 255*256 + 128 = 65408, so 16 bits never overflow.
    assign sum_c = prod_r_q + prod_g_q + prod_b_q + ACC_W'(LUMA_RND);

    // Stage 1: per-channel weighted products.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s1_q <= 1'b0;
            prod_r_q   <= '0;
            prod_g_q   <= '0;
            prod_b_q   <= '0;
        end else begin
            valid_s1_q <= valid_i;
            prod_r_q   <= ACC_W'(LUMA_WR) * ACC_W'(rgb_i.r);
            prod_g_q   <= ACC_W'(LUMA_WG) * ACC_W'(rgb_i.g);
            prod_b_q   <= ACC_W'(LUMA_WB) * ACC_W'(rgb_i.b);
        end
    end

    // Stage 2: rounded, shifted luma; held at zero on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_s2_q <= 1'b0;
            gray_q     <= '0;
        end else begin
            valid_s2_q <= valid_s1_q;
            gray_q     <= valid_s1_q ? PIX_W'(sum_c >> LUMA_SH) : '0;
        end
    end

    assign valid_o = valid_s2_q;
    assign gray_o  = gray_q;

endmodule

// File: rtl/rgb2gray_stream.sv
// RGB888 stream to 8-bit luma with frame tracking (row/col/eof/frame_err).
// Optional per-frame min/max/sum statistics when GRAY_STATS_EN is defined.
module rgb2gray_stream
    import img_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = 320,
    parameter int unsigned IMAGE_HEIGHT = 240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [23:0]      pix_rgb,
    output logic             gray_valid,
    output logic [PIX_W-1:0] gray,
    output coord_t           gray_row,
    output coord_t           gray_col,
    output logic             gray_eof,
    output logic             frame_err,
    output logic             stat_valid,
    output logic [PIX_W-1:0] stat_min,
    output logic [PIX_W-1:0] stat_max,
    output logic [SUM_W-1:0] stat_sum
);

    localparam coord_t LAST_COL = COORD_W'(IMAGE_WIDTH - 1);
    localparam coord_t LAST_ROW = COORD_W'(IMAGE_HEIGHT - 1);

    frame_state_e state_q, state_d;
    coord_t       row_q, row_d;
    coord_t       col_q, col_d;
    logic         accept_c;
    pix_tag_t     tag_c;
    pix_tag_t     tag_s1_q, tag_s2_q;
    rgb_t         rgb_c;
    logic         mac_valid;
    logic [PIX_W-1:0] mac_gray;

    assign rgb_c = pix_rgb;

    // Frame state and position of the next expected pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Accept/drop decision, tag of the incoming pixel, and counter advance.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        accept_c = 1'b0;
        tag_c    = '0;
        case (state_q)
            ST_IDLE: begin
                if (pix_valid && pix_sof) begin
                    accept_c = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (pix_valid) begin
                    accept_c = 1'b1;
                    if (pix_sof) begin
                        // Restart wins over any in-progress position, including the last pixel.
                        tag_c.err = 1'b1;
                    end else begin
                        tag_c.row = row_q;
                        tag_c.col = col_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (accept_c) begin
            tag_c.eof = (tag_c.row == LAST_ROW) && (tag_c.col == LAST_COL);
            if (tag_c.eof) begin
                state_d = ST_IDLE;
                row_d   = '0;
                col_d   = '0;
            end else begin
                state_d = ST_ACTIVE;
                if (tag_c.col == LAST_COL) begin
                    col_d = '0;
                    row_d = tag_c.row + COORD_W'(1);
                end else begin
                    col_d = tag_c.col + COORD_W'(1);
                    row_d = tag_c.row;
                end
            end
        end
    end

    // Tag delay line, matched to the two datapath stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_s1_q <= '0;
            tag_s2_q <= '0;
        end else begin
            tag_s1_q <= accept_c ? tag_c : '0;
            tag_s2_q <= tag_s1_q;
        end
    end

    rgb_luma_mac u_mac (
        .clk     (clk),
        .rst     (rst),
        .valid_i (accept_c),
        .rgb_i   (rgb_c),
        .valid_o (mac_valid),
        .gray_o  (mac_gray)
    );

    assign gray_valid = mac_valid;
    assign gray       = mac_gray;
    assign gray_row   = tag_s2_q.row;
    assign gray_col   = tag_s2_q.col;
    assign gray_eof   = tag_s2_q.eof;
    assign frame_err  = tag_s2_q.err;

`ifdef GRAY_STATS_EN
    logic [PIX_W-1:0] run_min_q, run_max_q, cur_min_c, cur_max_c;
    logic [SUM_W-1:0] run_sum_q, cur_sum_c;
    logic [PIX_W-1:0] stat_min_q, stat_max_q;
    logic [SUM_W-1:0] stat_sum_q;
    logic             stat_valid_q;
    logic             first_c;

    // Every frame (fresh or restarted) begins with the pixel output at (0,0).
    assign first_c = mac_valid && (tag_s2_q.row == '0) && (tag_s2_q.col == '0);

    // Running statistics including the pixel currently on the output.
    always_comb begin
        cur_min_c = run_min_q;
        cur_max_c = run_max_q;
        cur_sum_c = run_sum_q;
        if (mac_valid) begin
            if (first_c) begin
                cur_min_c = mac_gray;
                cur_max_c = mac_gray;
                cur_sum_c = SUM_W'(mac_gray);
            end else begin
                if (mac_gray < run_min_q) begin
                    cur_min_c = mac_gray;
                end
                if (mac_gray > run_max_q) begin
                    cur_max_c = mac_gray;
                end
                cur_sum_c = run_sum_q + SUM_W'(mac_gray);
            end
        end
    end

    // Accumulate per output pixel; publish once when the eof pixel goes out.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_min_q    <= '0;
            run_max_q    <= '0;
            run_sum_q    <= '0;
            stat_min_q   <= '0;
            stat_max_q   <= '0;
            stat_sum_q   <= '0;
            stat_valid_q <= 1'b0;
        end else begin
            stat_valid_q <= mac_valid && tag_s2_q.eof;
            if (mac_valid) begin
                run_min_q <= cur_min_c;
                run_max_q <= cur_max_c;
                run_sum_q <= cur_sum_c;
            end
            if (mac_valid && tag_s2_q.eof) begin
                stat_min_q <= cur_min_c;
                stat_max_q <= cur_max_c;
                stat_sum_q <= cur_sum_c;
            end
        end
    end

    assign stat_valid = stat_valid_q;
    assign stat_min   = stat_min_q;
    assign stat_max   = stat_max_q;
    assign stat_sum   = stat_sum_q;
`else
    assign stat_valid = 1'b0;
    assign stat_min   = '0;
    assign stat_max   = '0;
    assign stat_sum   = '0;
`endif

endmodule
